// File: rtl/mult_34.sv
// mult_34 -- pipelined 17x17 unsigned multiplier with a 34-bit product.
//
// This is the basic multiply primitive in the ElGamal modular-arithmetic
// datapath. Operands A and B arrive on two AXI-Stream style channels. They are
// joined, so a pair is consumed only when both are valid. The product leaves on
// one AXI-Stream output. With output_tready held high the unit accepts one pair
// and delivers one product per clock. The latency is 3 clocks, counting the
// accept edge.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active-low (0 = in reset)
//   input_a_tdata   operand A, unsigned, 17 bits
//   input_a_tvalid  operand A valid
//   input_a_tready  pair accepted this cycle (stage-1 space and both operands valid)
//   input_b_tdata   operand B, unsigned, 17 bits
//   input_b_tvalid  operand B valid
//   input_b_tready  identical to input_a_tready
//   output_tdata    product A*B, unsigned, 34 bits
//   output_tvalid   product valid
//   output_tready   downstream ready
module mult_34 (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] input_a_tdata,
  input  logic        input_a_tvalid,
  output logic        input_a_tready,
  input  logic [16:0] input_b_tdata,
  input  logic        input_b_tvalid,
  output logic        input_b_tready,
  output logic [33:0] output_tdata,
  output logic        output_tvalid,
  input  logic        output_tready
);

  localparam int DATA_W = 17;
  localparam int PROD_W = 34;

  // Each operand is split into a 9-bit low half and an 8-bit high half.
  // The four partial products are then recombined with shifts.
  function automatic logic [17:0] mul_9x9(input logic [8:0] x, input logic [8:0] y);
    return {9'd0, x} * {9'd0, y};
  endfunction

  function automatic logic [16:0] mul_9x8(input logic [8:0] x, input logic [7:0] y);
    return {8'd0, x} * {9'd0, y};
  endfunction

  function automatic logic [15:0] mul_8x8(input logic [7:0] x, input logic [7:0] y);
    return {8'd0, x} * {8'd0, y};
  endfunction

  // The true result is at most (2^17-1)^2, which is below 2^34.
  // The 34-bit sum therefore never wraps.
  function automatic logic [PROD_W-1:0] recombine(input logic [15:0] phh,
                                                  input logic [16:0] plh,
                                                  input logic [16:0] phl,
                                                  input logic [17:0] pll);
    logic [17:0] mid;
    mid = {1'b0, plh} + {1'b0, phl};
    return {phh, 18'd0} + {7'd0, mid, 9'd0} + {16'd0, pll};
  endfunction

  logic [DATA_W-1:0] a_p0, b_p0;
  logic              vld_p0;
  logic [17:0]       pll_p1;
  logic [16:0]       plh_p1, phl_p1;
  logic [15:0]       phh_p1;
  logic              vld_p1;
  logic [PROD_W-1:0] prod_p2;
  logic              vld_p2;

  logic rdy_p0, rdy_p1, rdy_p2;
  logic accept;

  // Each stage can load when it is empty or when its content moves on.
  // The ready chain is combinational from output_tready back to the inputs,
  // so a full pipe can still stream one pair per clock.
  assign rdy_p2 = !vld_p2 || output_tready;
  assign rdy_p1 = !vld_p1 || rdy_p2;
  assign rdy_p0 = !vld_p0 || rdy_p1;

  // Gating with rst keeps the ready outputs low while reset is asserted.
  assign accept         = rst && rdy_p0 && input_a_tvalid && input_b_tvalid;
  assign input_a_tready = accept;
  assign input_b_tready = accept;

  assign output_tdata  = prod_p2;
  assign output_tvalid = vld_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_p0    <= '0;
      b_p0    <= '0;
      vld_p0  <= 1'b0;
      pll_p1  <= '0;
      plh_p1  <= '0;
      phl_p1  <= '0;
      phh_p1  <= '0;
      vld_p1  <= 1'b0;
      prod_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      // stage p0: capture the joined operand pair
      if (rdy_p0) begin
        vld_p0 <= accept;
        if (accept) begin
          a_p0 <= input_a_tdata;
          b_p0 <= input_b_tdata;
        end
      end

      // stage p1: four partial products from the hi/lo operand halves
      if (rdy_p1) begin
        vld_p1 <= vld_p0;
        if (vld_p0) begin
          pll_p1 <= mul_9x9(a_p0[8:0],  b_p0[8:0]);
          plh_p1 <= mul_9x8(a_p0[8:0],  b_p0[16:9]);
          phl_p1 <= mul_9x8(b_p0[8:0],  a_p0[16:9]);
          phh_p1 <= mul_8x8(a_p0[16:9], b_p0[16:9]);
        end
      end

      // stage p2: shifted sum of the partial products
      if (rdy_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          prod_p2 <= recombine(phh_p1, plh_p1, phl_p1, pll_p1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_34.sv
module tb_mult_34;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] input_a_tdata;
  logic        input_a_tvalid;
  logic        input_a_tready;
  logic [16:0] input_b_tdata;
  logic        input_b_tvalid;
  logic        input_b_tready;
  logic [33:0] output_tdata;
  logic        output_tvalid;
  logic        output_tready;

  int checks = 0;
  int errors = 0;

  mult_34 dut (
    .clk            (clk),
    .rst            (rst),
    .input_a_tdata  (input_a_tdata),
    .input_a_tvalid (input_a_tvalid),
    .input_a_tready (input_a_tready),
    .input_b_tdata  (input_b_tdata),
    .input_b_tvalid (input_b_tvalid),
    .input_b_tready (input_b_tready),
    .output_tdata   (output_tdata),
    .output_tvalid  (output_tvalid),
    .output_tready  (output_tready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pair(input logic [16:0] a, input logic [16:0] b);
    input_a_tdata  = a;
    input_b_tdata  = b;
    input_a_tvalid = 1'b1;
    input_b_tvalid = 1'b1;
  endtask

  task automatic idle();
    input_a_tvalid = 1'b0;
    input_b_tvalid = 1'b0;
  endtask

  logic [33:0] exp_q[$];
  logic [33:0] exp_v;
  logic [16:0] ra, rb;
  logic        presenting, acc, otx;
  int          sent, rcvd, cycles;

  initial begin
    // Reset state, with valid operands already presented
    rst = 1'b0;
    output_tready = 1'b1;
    pair(17'd5, 17'd7);
    #1;
    chk("reset_tvalid", {33'd0, output_tvalid}, 34'd0);
    chk("reset_tdata", output_tdata, 34'd0);
    chk("reset_tready", {33'd0, input_a_tready}, 34'd0);
    step();
    chk("reset_hold_tready", {33'd0, input_a_tready}, 34'd0);
    idle();
    #2;
    rst = 1'b1;
    step();
    chk("post_reset_tvalid", {33'd0, output_tvalid}, 34'd0);

    // Basic: single pair, 3-clock latency
    pair(17'd690, 17'd2137);
    #1;
    chk("basic_tready_a", {33'd0, input_a_tready}, 34'd1);
    chk("basic_tready_b", {33'd0, input_b_tready}, 34'd1);
    step();
    idle();
    chk("basic_lat1", {33'd0, output_tvalid}, 34'd0);
    step();
    chk("basic_lat2", {33'd0, output_tvalid}, 34'd0);
    step();
    chk("basic_tvalid", {33'd0, output_tvalid}, 34'd1);
    chk("basic_tdata", output_tdata, 34'd1474530);
    step();
    chk("basic_single", {33'd0, output_tvalid}, 34'd0);

    // Streaming: back-to-back pairs
    pair(17'd1, 17'd1);
    #1;
    chk("stream_tready", {33'd0, input_a_tready}, 34'd1);
    step();
    pair(17'd131071, 17'd131071);
    step();
    pair(17'd0, 17'd12345);
    step();
    chk("stream_out0", output_tdata, 34'd1);
    chk("stream_v0", {33'd0, output_tvalid}, 34'd1);
    pair(17'd65536, 17'd2);
    step();
    chk("stream_out1", output_tdata, 34'd17179607041);
    idle();
    step();
    chk("stream_out2", output_tdata, 34'd0);
    chk("stream_v2", {33'd0, output_tvalid}, 34'd1);
    step();
    chk("stream_out3", output_tdata, 34'd131072);
    step();
    chk("stream_end", {33'd0, output_tvalid}, 34'd0);

    // Join: a lone A waits for B
    input_a_tdata  = 17'd3;
    input_a_tvalid = 1'b1;
    input_b_tdata  = 17'd5;
    input_b_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("join_wait_a", {33'd0, input_a_tready}, 34'd0);
      chk("join_wait_b", {33'd0, input_b_tready}, 34'd0);
      step();
    end
    chk("join_no_out", {33'd0, output_tvalid}, 34'd0);
    input_b_tvalid = 1'b1;
    #1;
    chk("join_tready", {33'd0, input_b_tready}, 34'd1);
    step();
    idle();
    step();
    step();
    chk("join_tvalid", {33'd0, output_tvalid}, 34'd1);
    chk("join_tdata", output_tdata, 34'd15);
    step();
    chk("join_single", {33'd0, output_tvalid}, 34'd0);

    // Back-pressure: 5 pairs with output_tready low
    output_tready = 1'b0;
    pair(17'd10, 17'd10);
    step();
    pair(17'd20, 17'd3);
    step();
    pair(17'd7, 17'd9);
    step();
    pair(17'd100, 17'd100);
    #1;
    chk("bp_full_tready", {33'd0, input_a_tready}, 34'd0);
    chk("bp_tvalid", {33'd0, output_tvalid}, 34'd1);
    chk("bp_tdata", output_tdata, 34'd100);
    step();
    step();
    chk("bp_hold_tdata", output_tdata, 34'd100);
    chk("bp_hold_tvalid", {33'd0, output_tvalid}, 34'd1);
    chk("bp_hold_tready", {33'd0, input_a_tready}, 34'd0);
    output_tready = 1'b1;
    #1;
    chk("bp_release_tready", {33'd0, input_a_tready}, 34'd1);
    step();
    chk("bp_drain1", output_tdata, 34'd60);
    pair(17'd131071, 17'd1);
    step();
    chk("bp_drain2", output_tdata, 34'd63);
    idle();
    step();
    chk("bp_drain3", output_tdata, 34'd10000);
    step();
    chk("bp_drain4", output_tdata, 34'd131071);
    chk("bp_drain4_v", {33'd0, output_tvalid}, 34'd1);
    step();
    chk("bp_empty", {33'd0, output_tvalid}, 34'd0);

    // Asynchronous reset with products in flight
    pair(17'd2, 17'd3);
    step();
    step();
    step();
    chk("rst_pre_tdata", output_tdata, 34'd6);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_tvalid", {33'd0, output_tvalid}, 34'd0);
    chk("rst_async_tdata", output_tdata, 34'd0);
    chk("rst_async_tready", {33'd0, input_a_tready}, 34'd0);
    idle();
    step();
    #2;
    rst = 1'b1;
    step();
    chk("rst_flushed0", {33'd0, output_tvalid}, 34'd0);
    step();
    chk("rst_flushed1", {33'd0, output_tvalid}, 34'd0);
    pair(17'd11, 17'd13);
    step();
    idle();
    step();
    step();
    chk("rst_new_tvalid", {33'd0, output_tvalid}, 34'd1);
    chk("rst_new_tdata", output_tdata, 34'd143);
    step();
    chk("rst_new_single", {33'd0, output_tvalid}, 34'd0);

    // Random pairs, random back-pressure, checked against a FIFO of a*b
    presenting = 1'b0;
    sent = 0;
    rcvd = 0;
    cycles = 0;
    while (rcvd < 1000 && cycles < 20000) begin
      if (!presenting) begin
        if (sent < 1000 && $urandom_range(3) != 0) begin
          ra = 17'($urandom);
          rb = 17'($urandom);
          pair(ra, rb);
          presenting = 1'b1;
          sent++;
        end else begin
          idle();
        end
      end
      output_tready = ($urandom_range(2) != 0);
      #1;
      acc = input_a_tready;
      otx = output_tvalid && output_tready;
      if (input_a_tready !== input_b_tready) begin
        chk("rand_tready_eq", {33'd0, input_b_tready}, {33'd0, input_a_tready});
      end
      if (otx) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious", {33'd0, output_tvalid}, 34'd0);
        end else begin
          exp_v = exp_q.pop_front();
          chk("rand_prod", output_tdata, exp_v);
        end
        rcvd++;
      end
      if (acc) begin
        exp_q.push_back({17'd0, input_a_tdata} * {17'd0, input_b_tdata});
        presenting = 1'b0;
      end
      step();
      cycles++;
    end
    chk("rand_count", 34'(rcvd), 34'd1000);
    chk("rand_queue_empty", 34'(exp_q.size()), 34'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
